avalon_pio_poller: RTL



---
 rtl/avalon_pio_poller_pkg.sv | 21 ++
 rtl/avalon_pio_poller_if.sv | 34 +++
 rtl/pio_debounce.sv | 63 ++++++
 rtl/avalon_pio_poller.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/avalon_pio_poller_pkg.sv
// Shared types and helpers for the Avalon PIO poller.
package avalon_pio_poller_pkg;

  // Poll sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWait,
    StEval
  } poll_state_e;

  localparam int unsigned DefaultPollPeriod = 50000;

  // Width of a down-counter that must hold values 0 .. count-1 (at least 1 bit).
  function automatic int unsigned timer_width(input int unsigned count);
    return (count > 2) ? $clog2(count) : 1;
  endfunction

  localparam int unsigned DefaultTimerW = timer_width(DefaultPollPeriod);

endpackage

// File: rtl/avalon_pio_poller_if.sv
// Bus bundle for the poller: Avalon-MM read master side plus the event valid/ready stream.
interface avalon_pio_poller_if #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned ADDR_W = 2
);

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [31:0]       avm_readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // Poller side.
  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    output out_data,
    output out_valid,
    input  out_ready
  );

  // PIO slave plus event consumer side.
  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/pio_debounce.sv
// Debouncer for polled PIO samples: a change is accepted once DEBOUNCE_CNT consecutive
// evaluated samples agree and differ from the current stable value.
module pio_debounce
  import avalon_pio_poller_pkg::*;
#(
  parameter int unsigned DATA_W       = 14,
  parameter int unsigned DEBOUNCE_CNT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              eval,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] stable_data,
  output logic              change,
  output logic [DATA_W-1:0] change_data
);

  localparam int unsigned CntW = timer_width(DEBOUNCE_CNT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(DEBOUNCE_CNT);

  logic [DATA_W-1:0] cand_q, cand_d;
  logic [DATA_W-1:0] stable_q, stable_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Candidate tracking and acceptance, evaluated only in the EVAL cycle.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    change   = 1'b0;
    if (eval) begin
      if (sample == cand_q) begin
        if (cnt_q != MaxCnt) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else begin
        cand_d = sample;
        cnt_d  = CntW'(1);
      end
      if ((cnt_d == MaxCnt) && (cand_d != stable_q)) begin
        stable_d = cand_d;
        change   = 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_data = stable_q;
  assign change_data = cand_d;

endmodule

// File: rtl/avalon_pio_poller.sv
// Avalon-MM read master that polls a PIO data register every POLL_PERIOD cycles, debounces
// the field and emits each accepted change on a single-entry valid/ready output.
// Optional edge capture register: define AVALON_PIO_POLLER_EDGE_CAPTURE_EN.
module avalon_pio_poller
  import avalon_pio_poller_pkg::*;
#(
  parameter int unsigned DATA_W       = 14,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned POLL_ADDR    = 0,
  parameter int unsigned POLL_PERIOD  = 50000,
  parameter int unsigned DEBOUNCE_CNT = 3,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  avalon_pio_poller_if.master bus,
  output logic [DATA_W-1:0]   stable_data,
  output logic                overflow,
  input  logic                overflow_clr
`ifdef AVALON_PIO_POLLER_EDGE_CAPTURE_EN
  ,
  input  logic [DATA_W-1:0]   edge_clr,
  output logic [DATA_W-1:0]   edge_capture
`endif
);

  localparam int unsigned TimerW = timer_width(POLL_PERIOD);
  localparam int unsigned LatW   = timer_width(READ_LATENCY);
  localparam logic [TimerW-1:0] Reload = TimerW'(POLL_PERIOD - 1);

  poll_state_e       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              eval;
  logic              change;
  logic [DATA_W-1:0] change_data;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       unused_readdata;

  // Upper readdata bits are deliberately ignored.
  assign unused_readdata = bus.avm_readdata;

  // Free-running poll timer; keeps counting through READ/WAIT/EVAL so issue spacing is exact.
  always_comb begin
    timer_d = timer_q;
    if (!enable || (timer_q == '0)) begin
      timer_d = Reload;
    end else begin
      timer_d = timer_q - TimerW'(1);
    end
  end

  // Poll sequencer: issue one read, wait the fixed latency, capture, evaluate.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    sample_d = sample_q;
    eval     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && (timer_q == '0)) begin
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StWait;
        lat_d   = LatW'(READ_LATENCY - 1);
      end
      StWait: begin
        if (lat_q == '0) begin
          sample_d = bus.avm_readdata[DATA_W-1:0];
          state_d  = StEval;
        end else begin
          lat_d = lat_q - LatW'(1);
        end
      end
      StEval: begin
        eval    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  pio_debounce #(
    .DATA_W       (DATA_W),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .eval        (eval),
    .sample      (sample_q),
    .stable_data (stable_data),
    .change      (change),
    .change_data (change_data)
  );

  // Single-entry event register; a newer event overwrites an unaccepted one and flags overflow.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (change) begin
      out_data_d  = change_data;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    // Set wins over clear.
    overflow_d = (change && out_valid_q && !bus.out_ready) || (overflow_q && !overflow_clr);
  end

  // Sequencer, timer and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      timer_q     <= Reload;
      lat_q       <= '0;
      sample_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lat_q       <= lat_d;
      sample_q    <= sample_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.avm_address = ADDR_W'(POLL_ADDR);
  assign bus.avm_read    = (state_q == StRead);
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign overflow        = overflow_q;

`ifdef AVALON_PIO_POLLER_EDGE_CAPTURE_EN
  logic [DATA_W-1:0] edge_q, edge_d;

  // Rising-bit capture on accepted changes; set wins over clear.
  always_comb begin
    edge_d = edge_q & ~edge_clr;
    if (change) begin
      edge_d = edge_d | (change_data & ~stable_data);
    end
  end

  // Edge capture register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_q <= '0;
    end else begin
      edge_q <= edge_d;
    end
  end

  assign edge_capture = edge_q;
`endif

endmodule
